// File: rtl/alu_pkg.sv
// Shared ALU definitions: default widths, MIPS funct opcodes and sequencer state encoding.
package alu_pkg;

  localparam int unsigned NB_DATA_DEF = 6;
  localparam int unsigned NB_OP_DEF   = 6;
  localparam int unsigned NB_CNT      = 4;

  localparam logic [NB_OP_DEF-1:0] OP_ADD = 6'b100000;
  localparam logic [NB_OP_DEF-1:0] OP_SUB = 6'b100010;
  localparam logic [NB_OP_DEF-1:0] OP_AND = 6'b100100;
  localparam logic [NB_OP_DEF-1:0] OP_OR  = 6'b100101;
  localparam logic [NB_OP_DEF-1:0] OP_XOR = 6'b100110;
  localparam logic [NB_OP_DEF-1:0] OP_NOR = 6'b100111;
  localparam logic [NB_OP_DEF-1:0] OP_SRL = 6'b000010;
  localparam logic [NB_OP_DEF-1:0] OP_SRA = 6'b000011;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/alu_operand_sequencer_if.sv
// Word-input, ALU-operand and result handshake bundle between the sequencer and its neighbours.
interface alu_operand_sequencer_if
  import alu_pkg::*;
#(
  parameter int unsigned NB_DATA = NB_DATA_DEF,
  parameter int unsigned NB_OP   = NB_OP_DEF
);

  logic [NB_DATA-1:0] i_data;
  logic               i_valid;
  logic               o_ready;
  logic [NB_DATA-1:0] o_A;
  logic [NB_DATA-1:0] o_B;
  logic [NB_OP-1:0]   o_OP;
  logic [NB_DATA-1:0] i_res;
  logic [NB_DATA-1:0] o_res;
  logic               o_res_valid;
  logic               i_res_ready;
  logic               o_err;
  logic               o_busy;

  // Sequencer side
  modport master (
    input  i_data, i_valid, i_res, i_res_ready,
    output o_ready, o_A, o_B, o_OP, o_res, o_res_valid, o_err, o_busy
  );

  // Word source, ALU and result consumer side
  modport slave (
    output i_data, i_valid, i_res, i_res_ready,
    input  o_ready, o_A, o_B, o_OP, o_res, o_res_valid, o_err, o_busy
  );

endinterface

// File: rtl/alu_op_check.sv
// Combinational decoder: flags opcodes the ALU implements.
module alu_op_check
  import alu_pkg::*;
#(
  parameter int unsigned NB_OP = NB_OP_DEF
) (
  input  logic [NB_OP-1:0] op,
  output logic             supported_c
);

  always_comb begin
    supported_c = 1'b0;
    case (op)
      NB_OP'(OP_ADD), NB_OP'(OP_SUB), NB_OP'(OP_AND), NB_OP'(OP_OR),
      NB_OP'(OP_XOR), NB_OP'(OP_NOR), NB_OP'(OP_SRL), NB_OP'(OP_SRA):
        supported_c = 1'b1;
      default:
        supported_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Collects A, B, OP words, drives a clocked ALU with stable registered operands,
// waits the ALU latency and hands the captured result to a valid/ready consumer.
module alu_operand_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned NB_DATA = NB_DATA_DEF,
  parameter int unsigned NB_OP   = NB_OP_DEF,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  alu_operand_sequencer_if.master bus
);

  state_t             state;
  logic [NB_DATA-1:0] shadow_a;
  logic [NB_DATA-1:0] shadow_b;
  logic [NB_CNT-1:0]  cnt;

  logic               xfer_c;
  logic [NB_OP-1:0]   op_word_c;
  logic               op_ok_c;

  assign xfer_c    = bus.i_valid && bus.o_ready;
  assign op_word_c = bus.i_data[NB_OP-1:0];

  alu_op_check #(
    .NB_OP (NB_OP)
  ) u_op_check (
    .op          (op_word_c),
    .supported_c (op_ok_c)
  );

  // Sequencer FSM; o_ready/o_busy are kept as registered decodes of the next state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= S_A;
      shadow_a        <= '0;
      shadow_b        <= '0;
      cnt             <= '0;
      bus.o_A         <= '0;
      bus.o_B         <= '0;
      bus.o_OP        <= '0;
      bus.o_res       <= '0;
      bus.o_res_valid <= 1'b0;
      bus.o_err       <= 1'b0;
      bus.o_busy      <= 1'b0;
      bus.o_ready     <= 1'b1;
    end else begin
      bus.o_err <= 1'b0;
      case (state)
        S_A: begin
          if (xfer_c) begin
            shadow_a <= bus.i_data;
            state    <= S_B;
          end
        end
        S_B: begin
          if (xfer_c) begin
            shadow_b <= bus.i_data;
            state    <= S_OP;
          end
        end
        S_OP: begin
          if (xfer_c) begin
            if (op_ok_c) begin
              bus.o_A     <= shadow_a;
              bus.o_B     <= shadow_b;
              bus.o_OP    <= op_word_c;
              cnt         <= NB_CNT'(ALU_LAT);
              bus.o_ready <= 1'b0;
              bus.o_busy  <= 1'b1;
              state       <= S_EXEC;
            end else begin
              // Rejected opcode: drop the shadowed operands, keep the ALU inputs
              bus.o_err <= 1'b1;
              state     <= S_A;
            end
          end
        end
        S_EXEC: begin
          if (cnt == '0) begin
            bus.o_res       <= bus.i_res;
            bus.o_res_valid <= 1'b1;
            state           <= S_DONE;
          end else begin
            cnt <= cnt - NB_CNT'(1);
          end
        end
        S_DONE: begin
          if (bus.i_res_ready) begin
            bus.o_res_valid <= 1'b0;
            bus.o_ready     <= 1'b1;
            bus.o_busy      <= 1'b0;
            state           <= S_A;
          end
        end
        default: begin
          bus.o_res_valid <= 1'b0;
          bus.o_ready     <= 1'b1;
          bus.o_busy      <= 1'b0;
          state           <= S_A;
        end
      endcase
    end
  end

  // An error pulse only ever follows a rejected OP word, i.e. back in S_A
  a_err_idle: assert property (@(posedge clock) disable iff (!reset)
    bus.o_err |-> (bus.o_ready && !bus.o_busy));

  a_valid_busy: assert property (@(posedge clock) disable iff (!reset)
    bus.o_res_valid |-> (bus.o_busy && !bus.o_ready));

endmodule
